seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//  Multi-cycle restoring divider; inverse of the lab's combinational 3x3 array multiplier.
//  Divides a 2W-bit dividend (a multiplier product) by a W-bit divisor.
//  Produces a 2W-bit quotient and a W-bit remainder, one quotient bit per clock.
//  Used to check multiplier output and as a stand-alone lab datapath unit.
// PARAMETERS
//  W  3  divisor/remainder width; dividend and quotient are 2W bits
// PORTS
//  clk        in   1   system clock, rising edge
//  rst        in   1   synchronous, active-high reset
//  start      in   1   request; sampled only while ready=1
//  dividend   in   2W  numerator, captured on the accepting edge
//  divisor    in   W   denominator, captured on the accepting edge
//  ready      out  1   1 in IDLE and DONE: start will be accepted
//  busy       out  1   1 while iterating (RUN)
//  done       out  1   one-cycle pulse; q/r/err valid in that cycle
//  quotient   out  2W  result, held until the next accepted start
//  remainder  out  W   result, held until the next accepted start
//  div_err    out  1   divide-by-zero flag, held with the result
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge): state=IDLE; ready=1; busy=0; done=0; quotient=0;
//    remainder=0; div_err=0; iteration counter=0.
//  - rst overrides everything, including mid-RUN. The operation in flight is discarded.
//  - FSM: IDLE -start-> RUN (divisor!=0) or DONE (divisor==0); RUN -count==2W-> DONE;
//    DONE -> IDLE, or DONE -start-> RUN/DONE (back-to-back accept).
//  - start while busy=1 is ignored. Operand changes during RUN have no effect.
//  - Accept edge: latch divisor; quotient shift reg <= dividend; partial rem <= 0; count <= 0.
//  - Iteration (one per edge in RUN), partial rem is W+1 bits:
//    t = {rem[W-1:0], q[2W-1]}; q <= {q[2W-2:0], t>=d}; rem <= (t>=d) ? t-d : t.
//  - Iterations are unsigned only. The compare/subtract is done at W+1 bits, with no overflow.
//  - Latency: start high in cycle 0 -> done high in cycle 2W+1 (cycle 7 for W=3).
//  - Throughput: one result every 2W+1 cycles.
//  - divisor==0: no iterations. done in cycle 1; div_err=1; quotient=all ones; remainder=0.
//  - div_err clears on the next accepted start.
//  - Outputs are registered. Results change only on the edge that sets done.
//  - dividend==0: full iteration count; result q=0, r=0.
// STRUCTURE
//  - divider_defs.vh (shared include): state localparams IDLE=2'd0, RUN=2'd1, DONE=2'd2;
//    default W.
//  - Sub-module div_step (combinational): inputs t[W:0], d[W-1:0];
//    outputs ge, diff[W:0].
//  - div_step subtracts with a fullAdder ripple chain (t + ~d + 1). ge = carry-out.
//  - Top level holds the FSM, counter (clog2(2W+1) bits), and q/rem registers.
// TESTING (W=3)
//  T1: 42/6 -> q=7, r=0, div_err=0; done exactly in cycle 7, busy in cycles 1-6.
//  T2: 47/5 -> q=9, r=2. Then 63/1 -> q=63, r=0. Then 0/7 -> q=0, r=0.
//  T3: 5/0 -> done in cycle 1, div_err=1, q=63, r=0.
//      Next start 20/3 -> div_err=0, q=6, r=2.
//  T4: rst=1 in cycle 3 of 20/3 -> next cycle ready=1, busy=0, done=0, q=0, r=0.
//      New 20/3 completes with q=6, r=2 at normal latency.
//  T5: start re-pulsed with 9/2 in cycles 2-5 of a 42/6 run -> ignored; result q=7, r=0.
//      start held in the DONE cycle with 9/2 -> accepted; q=4, r=1 seven cycles later.
//  T6: exhaustive: all a,b in 1..7, feed the multiplier product a*b as dividend with divisor b
//      -> q=a, r=0.
//      All 64x8 operand pairs checked against a reference model (/ and %).

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package seq_divider_pkg;

    localparam int W_DEF = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // One-bit full adder: returns {carry_out, sum}.
    function automatic logic [1:0] full_add(
        input logic a,
        input logic b,
        input logic ci
    );
        return {(a & b) | (ci & (a ^ b)), a ^ b ^ ci};
    endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: t - d through a ripple-carry chain.
module div_step
    import seq_divider_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W:0]   t,
    input  logic [W-1:0] d,
    output logic         ge,
    output logic [W:0]   diff
);

    logic [W:0]   nd;
    logic [W+1:0] c;
    logic [1:0]   fa;

    // t + ~d + 1; carry-out high means no borrow, i.e. t >= d
    always_comb begin
        nd   = ~{1'b0, d};
        c    = '0;
        c[0] = 1'b1;
        diff = '0;
        fa   = '0;
        for (int i = 0; i <= W; i++) begin
            fa       = full_add(t[i], nd[i], c[i]);
            diff[i]  = fa[0];
            c[i+1]   = fa[1];
        end
        ge = c[W+1];
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: 2W-bit dividend / W-bit divisor,
// one quotient bit per clock.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2*W-1:0]   dividend,
    input  logic [W-1:0]     divisor,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [2*W-1:0]   quotient,
    output logic [W-1:0]     remainder,
    output logic             div_err
);

    localparam int N  = 2 * W;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   q_q, q_d;
    logic [W-1:0]   rem_q, rem_d;
    logic [W-1:0]   dsr_q, dsr_d;
    logic [N-1:0]   quo_q, quo_d;
    logic [W-1:0]   remo_q, remo_d;
    logic           err_q, err_d;

    logic [W:0]     t;
    logic [W:0]     diff;
    logic           ge;
    logic           unused_diff_msb;

    // Partial remainder stays below the divisor, so its top bit is always 0
    assign t               = {rem_q, q_q[N-1]};
    assign unused_diff_msb = diff[W];

    div_step #(.W(W)) u_step (
        .t    (t),
        .d    (dsr_q),
        .ge   (ge),
        .diff (diff)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        rem_d   = rem_q;
        dsr_d   = dsr_q;
        quo_d   = quo_q;
        remo_d  = remo_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    dsr_d = divisor;
                    q_d   = dividend;
                    rem_d = '0;
                    cnt_d = '0;
                    err_d = 1'b0;
                    if (divisor == '0) begin
                        state_d = DONE;
                        quo_d   = '1;
                        remo_d  = '0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                q_d   = {q_q[N-2:0], ge};
                rem_d = ge ? diff[W-1:0] : t[W-1:0];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    quo_d   = q_d;
                    remo_d  = rem_d;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            rem_q   <= '0;
            dsr_q   <= '0;
            quo_q   <= '0;
            remo_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            rem_q   <= rem_d;
            dsr_q   <= dsr_d;
            quo_q   <= quo_d;
            remo_q  <= remo_d;
            err_q   <= err_d;
        end
    end

    assign ready     = (state_q == IDLE) || (state_q == DONE);
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign quotient  = quo_q;
    assign remainder = remo_q;
    assign div_err   = err_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and exhaustive checks of seq_divider with W=3.
module tb_seq_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [5:0] dividend;
    logic [2:0] divisor;
    logic       ready;
    logic       busy;
    logic       done;
    logic [5:0] quotient;
    logic [2:0] remainder;
    logic       div_err;

    int checks = 0;
    int errors = 0;

    seq_divider #(.W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_err   (div_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one operation from the current negedge and wait for done.
    task automatic op(input logic [5:0] a, input logic [2:0] b,
                      input string tag);
        logic [5:0] eq;
        logic [2:0] er;
        logic       ee;
        int         lat;
        int         el;
        if (b == 3'd0) begin
            eq = 6'd63; er = 3'd0; ee = 1'b1; el = 1;
        end else begin
            eq = a / b; er = a % b; ee = 1'b0; el = 7;
        end
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, lat, el);
        chk({tag, "_q"}, quotient, eq);
        chk({tag, "_r"}, remainder, er);
        chk({tag, "_err"}, div_err, ee);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_err", div_err, 0);
        rst = 1'b0;
        @(negedge clk);

        // T1: 42/6 with cycle-accurate busy/done
        dividend = 6'd42;
        divisor  = 3'd6;
        start    = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            start = 1'b0;
            chk($sformatf("t1_busy_c%0d", c), busy, 1);
            chk($sformatf("t1_done_c%0d", c), done, 0);
        end
        @(negedge clk);
        chk("t1_done_c7", done, 1);
        chk("t1_busy_c7", busy, 0);
        chk("t1_q", quotient, 7);
        chk("t1_r", remainder, 0);
        chk("t1_err", div_err, 0);
        @(negedge clk);
        chk("t1_done_c8", done, 0);
        chk("t1_ready_c8", ready, 1);
        chk("t1_q_hold", quotient, 7);

        // T2
        op(6'd47, 3'd5, "t2_47_5");
        op(6'd63, 3'd1, "t2_63_1");
        op(6'd0, 3'd7, "t2_0_7");

        // T3: divide by zero, then error clears
        op(6'd5, 3'd0, "t3_5_0");
        op(6'd20, 3'd3, "t3_20_3");

        // T4: reset in cycle 3 of a run
        @(negedge clk);
        dividend = 6'd20;
        divisor  = 3'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t4_ready", ready, 1);
        chk("t4_busy", busy, 0);
        chk("t4_done", done, 0);
        chk("t4_q", quotient, 0);
        chk("t4_r", remainder, 0);
        op(6'd20, 3'd3, "t4_20_3");

        // T5: start ignored while busy, accepted in DONE
        @(negedge clk);
        dividend = 6'd42;
        divisor  = 3'd6;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        dividend = 6'd9;
        divisor  = 3'd2;
        start    = 1'b1;
        repeat (4) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("t5_done_c7", done, 1);
        chk("t5_q", quotient, 7);
        chk("t5_r", remainder, 0);
        op(6'd9, 3'd2, "t5_9_2");

        // T6: multiplier products divide back exactly
        for (int a = 1; a <= 7; a++) begin
            for (int b = 1; b <= 7; b++) begin
                op(6'(a * b), 3'(b), $sformatf("t6p_%0d_%0d", a, b));
                chk($sformatf("t6p_%0d_%0d_a", a, b), quotient, a);
            end
        end

        // T6: all operand pairs against the / and % model
        for (int a = 0; a < 64; a++) begin
            for (int b = 0; b < 8; b++) begin
                op(6'(a), 3'(b), $sformatf("t6x_%0d_%0d", a, b));
            end
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
